fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end.
// Issues word-aligned fetches while the buffer has room. Returned words are queued with
// their PCs for decode. A redirect flushes the buffer and discards responses still in flight.
// Optional feature: define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets.
// A trapped target sets misalign_o and parks the unit in HALT until reset.
// Without FETCH_ALIGN_CHECK_EN the low two target bits are dropped.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        incr_pc_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] d_inst_o,
  output logic        d_valid_o,
  output logic [31:0] d_pc_o,
  output logic        misalign_o
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_r;
  logic [31:0] fetch_pc_r;
  logic [2:0]  outstanding_r;
  logic [2:0]  kill_r;
  logic [2:0]  count_r;
  logic [1:0]  buf_rd_r;
  logic [1:0]  buf_wr_r;
  logic [1:0]  pcq_rd_r;
  logic [1:0]  pcq_wr_r;
  logic [31:0] buf_inst_r [4];
  logic [31:0] buf_pc_r   [4];
  logic [31:0] pcq_r      [4];
  logic        misalign_r;

  logic        req_s;
  logic        grant_s;
  logic        rsp_kill_s;
  logic        rsp_take_s;
  logic        consumed_s;
  logic        pop_s;
  logic [2:0]  redirect_kill_s;
  logic [31:0] redir_target_s;
  logic        redir_misalign_s;

  // Circular pointer advance; the storage is sized for the largest legal DEPTH.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == 2'(DEPTH - 1)) begin
      return 2'd0;
    end else begin
      return p + 2'd1;
    end
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_target_s   = redirect_pc_i;
  assign redir_misalign_s = (redirect_pc_i[1:0] != 2'b00);
  assign misalign_o       = misalign_r;
`else
  assign redir_target_s   = redirect_pc_i & 32'hFFFF_FFFC;
  assign redir_misalign_s = 1'b0;
  assign misalign_o       = 1'b0;
`endif

  // Request gating, response classification and pop decision for the current cycle.
  always_comb begin
    req_s = 1'b0;
    if ((state_r == RUN) && !redirect_i &&
        (({1'b0, outstanding_r} + {1'b0, count_r}) < 4'(DEPTH))) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
    grant_s         = req_s & imem_gnt_i;
    rsp_kill_s      = imem_rvalid_i && (kill_r != 3'd0);
    rsp_take_s      = imem_rvalid_i && (kill_r == 3'd0) && (outstanding_r != 3'd0) &&
                      (state_r == RUN);
    consumed_s      = imem_rvalid_i && ((kill_r != 3'd0) || (outstanding_r != 3'd0));
    pop_s           = incr_pc_i && (count_r != 3'd0);
    // Every request still owed a response after this edge must be discarded.
    redirect_kill_s = kill_r + outstanding_r + {2'b00, grant_s} - {2'b00, consumed_s};
  end

  assign imem_req_o  = req_s;
  assign imem_addr_o = fetch_pc_r;
  assign d_valid_o   = (count_r != 3'd0);
  assign d_inst_o    = d_valid_o ? buf_inst_r[buf_rd_r] : NOP_INST;
  assign d_pc_o      = d_valid_o ? buf_pc_r[buf_rd_r] : 32'h0000_0000;

  // Control FSM with fetch PC, PC queue, instruction buffer and kill tracking.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= 3'd0;
      kill_r        <= 3'd0;
      count_r       <= 3'd0;
      buf_rd_r      <= 2'd0;
      buf_wr_r      <= 2'd0;
      pcq_rd_r      <= 2'd0;
      pcq_wr_r      <= 2'd0;
      misalign_r    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        buf_inst_r[i] <= 32'h0000_0000;
        buf_pc_r[i]   <= 32'h0000_0000;
        pcq_r[i]      <= 32'h0000_0000;
      end
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
        end
        RUN, FLUSH: begin
          if (redirect_i) begin
            fetch_pc_r    <= redir_target_s;
            outstanding_r <= 3'd0;
            count_r       <= 3'd0;
            buf_rd_r      <= 2'd0;
            buf_wr_r      <= 2'd0;
            pcq_rd_r      <= 2'd0;
            pcq_wr_r      <= 2'd0;
            if (redir_misalign_s) begin
              misalign_r <= 1'b1;
              kill_r     <= 3'd0;
              state_r    <= HALT;
            end else begin
              kill_r  <= redirect_kill_s;
              state_r <= (redirect_kill_s != 3'd0) ? FLUSH : RUN;
            end
          end else begin
            if (grant_s) begin
              fetch_pc_r      <= fetch_pc_r + 32'd4;
              pcq_r[pcq_wr_r] <= fetch_pc_r;
              pcq_wr_r        <= ptr_inc(pcq_wr_r);
            end
            if (rsp_kill_s) begin
              kill_r <= kill_r - 3'd1;
              if ((state_r == FLUSH) && (kill_r == 3'd1)) begin
                state_r <= RUN;
              end
            end
            if (rsp_take_s) begin
              buf_inst_r[buf_wr_r] <= imem_rdata_i;
              buf_pc_r[buf_wr_r]   <= pcq_r[pcq_rd_r];
              buf_wr_r             <= ptr_inc(buf_wr_r);
              pcq_rd_r             <= ptr_inc(pcq_rd_r);
            end
            if (pop_s) begin
              buf_rd_r <= ptr_inc(buf_rd_r);
            end
            outstanding_r <= outstanding_r + {2'b00, grant_s} - {2'b00, rsp_take_s};
            count_r       <= count_r + {2'b00, rsp_take_s} - {2'b00, pop_s};
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

endmodule
